// File: rtl/seq_shift_left_32bit.sv
// seq_shift_left_32bit: multi-cycle logical shift-left unit.
// Each clock in SHIFT resolves one binary stage of the shift amount
// (1, 2, 4, ... DATA_W/2 bits). Latency is always SHAMT_W cycles in SHIFT.
// Input and output both use a valid/ready handshake.
// Optional feature macro: SEQ_SHIFT_LEFT_ROTATE_EN adds rot_i, which turns
// every active stage into a left rotate instead of a logical shift.
module seq_shift_left_32bit #(
    parameter  int DATA_W  = 32,
    localparam int SHAMT_W = $clog2(DATA_W)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [DATA_W-1:0]  data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
`ifdef SEQ_SHIFT_LEFT_ROTATE_EN
    input  logic               rot_i,
`endif
    output logic               valid_o,
    input  logic               ready_i,
    output logic [DATA_W-1:0]  data_o,
    output logic               busy_o
);

    // Stage counter only needs to count 0 .. SHAMT_W-1.
    localparam int STAGE_W = $clog2(SHAMT_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_W-1:0]    data_q,  data_d;
    logic [SHAMT_W-1:0]   shamt_q, shamt_d;
    logic [STAGE_W-1:0]   stage_q, stage_d;
    logic                 rot_en;

`ifdef SEQ_SHIFT_LEFT_ROTATE_EN
    logic                 rot_q, rot_d;
    assign rot_en = rot_q;
`else
    assign rot_en = 1'b0;
`endif

    // Candidate result for every stage; the current stage picks one.
    logic [DATA_W-1:0] stage_val [SHAMT_W];

    genvar gi;
    generate
        for (gi = 0; gi < SHAMT_W; gi++) begin : g_stage
            localparam int S = 1 << gi;
            logic [DATA_W-1:0] shl_val;
            logic [DATA_W-1:0] rol_val;
            assign shl_val = data_q << S;
            assign rol_val = {data_q[DATA_W-1-S:0], data_q[DATA_W-1:DATA_W-S]};
            assign stage_val[gi] = rot_en ? rol_val : shl_val;
        end
    endgenerate

    logic [DATA_W-1:0] sel_val;
    logic              sel_bit;
    logic              last_stage;

    // Select the active stage's candidate and its shift-amount bit.
    always_comb begin
        sel_val = data_q;
        sel_bit = 1'b0;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (stage_q == STAGE_W'(i)) begin
                sel_val = stage_val[i];
                sel_bit = shamt_q[i];
            end
        end
    end

    assign last_stage = (stage_q == STAGE_W'(SHAMT_W - 1));

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        stage_d = stage_q;
`ifdef SEQ_SHIFT_LEFT_ROTATE_EN
        rot_d   = rot_q;
`endif
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    data_d  = data_i;
                    shamt_d = shamt_i;
                    stage_d = '0;
`ifdef SEQ_SHIFT_LEFT_ROTATE_EN
                    rot_d   = rot_i;
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (sel_bit) begin
                    data_d = sel_val;
                end
                if (last_stage) begin
                    state_d = DONE;
                end else begin
                    stage_d = stage_q + STAGE_W'(1);
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over any pending handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            data_q  <= '0;
            shamt_q <= '0;
            stage_q <= '0;
`ifdef SEQ_SHIFT_LEFT_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            stage_q <= stage_d;
`ifdef SEQ_SHIFT_LEFT_ROTATE_EN
            rot_q   <= rot_d;
`endif
        end
    end

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == DONE);
    assign busy_o  = (state_q != IDLE);
    assign data_o  = data_q;

endmodule

// File: tb/tb_seq_shift_left_32bit.sv
// Directed self-checking bench for seq_shift_left_32bit (DATA_W = 32).
// Expected results are pushed to a scoreboard queue at the accept edge and
// popped when the unit presents valid_o.
module tb_seq_shift_left_32bit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] data_i;
    logic [4:0]  shamt_i;
    logic        rot_r;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] data_o;
    logic        busy_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q [$];

    always #5 clk_i = ~clk_i;

    seq_shift_left_32bit #(.DATA_W(32)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .shamt_i (shamt_i),
`ifdef SEQ_SHIFT_LEFT_ROTATE_EN
        .rot_i   (rot_r),
`endif
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .busy_o  (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] d, input int sh, input logic rot);
        logic [31:0] r;
        r = d << sh;
        if (rot && sh != 0) r = r | (d >> (32 - sh));
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Offer an operand; the next edge is the accept edge (unit is IDLE).
    task automatic start_op(input logic [31:0] d, input int sh, input logic rot, input string tag);
        check({tag, "_ready_before"}, {31'b0, ready_o}, 32'd1);
        valid_i = 1'b1;
        data_i  = d;
        shamt_i = 5'(sh);
        rot_r   = rot;
        tick();
        valid_i = 1'b0;
        exp_q.push_back(model(d, sh, rot));
        $display("op %s: data=0x%08h shamt=%0d rot=%0b accepted", tag, d, sh, rot);
        check({tag, "_busy"}, {31'b0, busy_o}, 32'd1);
    endtask

    // Wait (bounded) for valid_o, check latency and the popped result.
    task automatic wait_result(input string tag);
        int lat;
        logic [31:0] exp;
        lat = 0;
        while (!valid_o && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd5);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        check({tag, "_data"}, data_o, exp);
        $display("result %s: data_o=0x%08h latency=%0d", tag, data_o, lat);
    endtask

    task automatic finish_ok(input string tag);
        tick();
        check({tag, "_valid_drop"}, {31'b0, valid_o}, 32'd0);
        check({tag, "_ready_back"}, {31'b0, ready_o}, 32'd1);
    endtask

    initial begin
        int saw;
        rst_i   = 1'b1;
        valid_i = 1'b0;
        data_i  = '0;
        shamt_i = '0;
        rot_r   = 1'b0;
        ready_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        check("rst_valid", {31'b0, valid_o}, 32'd0);
        check("rst_ready", {31'b0, ready_o}, 32'd1);
        check("rst_busy",  {31'b0, busy_o},  32'd0);
        check("rst_data",  data_o, 32'd0);

        // Basic shift
        start_op(32'h0000_00F1, 4, 1'b0, "basic");
        wait_result("basic");
        finish_ok("basic");

        // Boundaries
        start_op(32'hDEAD_BEEF, 0, 1'b0, "sh0");
        wait_result("sh0");
        finish_ok("sh0");
        start_op(32'h0000_0003, 31, 1'b0, "sh31");
        wait_result("sh31");
        finish_ok("sh31");
        start_op(32'hA5A5_A5A5, 13, 1'b0, "sh13");
        wait_result("sh13");
        finish_ok("sh13");

        // Backpressure: result held stable, inputs ignored while busy
        ready_i = 1'b0;
        start_op(32'h1234_5678, 8, 1'b0, "bp");
        wait_result("bp");
        for (int i = 0; i < 10; i++) begin
            valid_i = $urandom_range(0, 1);
            data_i  = $urandom();
            shamt_i = 5'($urandom_range(0, 31));
            tick();
            check("bp_hold_valid", {31'b0, valid_o}, 32'd1);
            check("bp_hold_data",  data_o, 32'h3456_7800);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        finish_ok("bp");
        tick();
        check("bp_no_spurious", {31'b0, busy_o}, 32'd0);

        // Reset in the 3rd SHIFT cycle discards the operation
        start_op(32'hFFFF_FFFF, 3, 1'b0, "rstmid");
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        exp_q.delete();
        check("rstmid_valid", {31'b0, valid_o}, 32'd0);
        check("rstmid_data",  data_o, 32'd0);
        check("rstmid_ready", {31'b0, ready_o}, 32'd1);
        saw = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid_o) saw++;
        end
        check("rstmid_never_valid", 32'(saw), 32'd0);
        start_op(32'h0000_0001, 1, 1'b0, "post_rst");
        wait_result("post_rst");
        finish_ok("post_rst");

`ifdef SEQ_SHIFT_LEFT_ROTATE_EN
        start_op(32'h8000_0001, 1, 1'b1, "rot1");
        wait_result("rot1");
        finish_ok("rot1");
        start_op(32'h8000_0001, 1, 1'b0, "norot1");
        wait_result("norot1");
        finish_ok("norot1");
        start_op(32'h1234_5678, 12, 1'b1, "rot12");
        wait_result("rot12");
        finish_ok("rot12");
`endif

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
